// File: rtl/histogram_pkg.sv
// Shared state encoding and default geometry for the histogram bin streamer.
package histogram_pkg;

  localparam int DEFAULT_NUM_BINS    = 256;
  localparam int DEFAULT_BIN_WIDTH   = 8;
  localparam int DEFAULT_COUNT_WIDTH = 32;

  // Saturation ceiling at the default width; narrower instances truncate it to all-ones.
  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_READ,
    ST_PRESENT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/hist_ram.sv
// Histogram bin storage: one write port, one read port, registered read (read-first on collision).
// Contents are not reset; the owner zeroes them explicitly.
module hist_ram
  import histogram_pkg::*;
#(
  parameter int DEPTH = DEFAULT_NUM_BINS,
  parameter int AW    = DEFAULT_BIN_WIDTH,
  parameter int DW    = DEFAULT_COUNT_WIDTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/histogram_bin_streamer.sv
// Accumulates a per-frame pixel histogram at 1 pixel/cycle, then replays non-empty bins as (i, n_i)
// one at a time; bin_valid holds until bin_ack, and clear aborts anything back to a fresh frame.
module histogram_bin_streamer
  import histogram_pkg::*;
#(
  parameter int NUM_BINS    = DEFAULT_NUM_BINS,
  parameter int BIN_WIDTH   = DEFAULT_BIN_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   pix_valid,
  input  logic [BIN_WIDTH-1:0]   pix,
  input  logic                   frame_end,
  output logic [BIN_WIDTH-1:0]   i,
  output logic [COUNT_WIDTH-1:0] n_i,
  output logic                   bin_valid,
  input  logic                   bin_ack,
  output logic                   busy,
  output logic                   stream_done,
  output logic [COUNT_WIDTH-1:0] total_pixels
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = COUNT_WIDTH'(COUNT_MAX);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [BIN_WIDTH-1:0]   BIN_ONE  = BIN_WIDTH'(1);
  localparam logic [BIN_WIDTH-1:0]   LAST_BIN = BIN_WIDTH'(NUM_BINS - 1);

  state_t                 state_q, state_d;
  logic [BIN_WIDTH-1:0]   idx_q, idx_d, i_d;
  logic [COUNT_WIDTH-1:0] n_d;

  logic                   accept;
  logic                   s1_vld, lw_vld;
  logic [BIN_WIDTH-1:0]   s1_addr, lw_addr;
  logic [COUNT_WIDTH-1:0] lw_data, base, s1_new;

  logic                   ram_we;
  logic [BIN_WIDTH-1:0]   ram_waddr, ram_raddr;
  logic [COUNT_WIDTH-1:0] ram_wdata, ram_rdata;

  hist_ram #(
    .DEPTH(NUM_BINS),
    .AW   (BIN_WIDTH),
    .DW   (COUNT_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // The previous pixel's write lands on the same edge our read was taken, so patch it in here.
  assign accept = (state_q == ST_ACCUM) && pix_valid && !clear;
  assign base   = (lw_vld && (lw_addr == s1_addr)) ? lw_data : ram_rdata;
  assign s1_new = (base == CNT_MAX) ? base : base + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld       <= 1'b0;
      lw_vld       <= 1'b0;
      total_pixels <= '0;
    end else begin
      s1_vld <= accept;
      lw_vld <= s1_vld;
      if (state_q == ST_CLEAR) begin
        total_pixels <= '0;
      end else if (accept && (total_pixels != CNT_MAX)) begin
        total_pixels <= total_pixels + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    s1_addr <= pix;
    lw_addr <= s1_addr;
    lw_data <= s1_new;
  end

  // Replay reads run one index ahead so READ sees bin[idx] without a wait cycle.
  always_comb begin
    ram_we    = s1_vld;
    ram_waddr = s1_addr;
    ram_wdata = s1_new;
    ram_raddr = pix;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = idx_q;
      ram_wdata = '0;
    end
    if (state_q == ST_DRAIN) begin
      ram_raddr = '0;
    end else if ((state_q == ST_READ) || (state_q == ST_PRESENT)) begin
      ram_raddr = idx_q + BIN_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    i_d     = i;
    n_d     = n_i;
    if (clear) begin
      state_d = ST_CLEAR;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          idx_d = idx_q + BIN_ONE;
          if (idx_q == LAST_BIN) begin
            state_d = ST_ACCUM;
            idx_d   = '0;
          end
        end
        ST_ACCUM: begin
          if (frame_end) begin
            state_d = ST_DRAIN;
            idx_d   = '0;
          end
        end
        ST_DRAIN: begin
          idx_d = idx_q + BIN_ONE;
          if (idx_q == BIN_ONE) begin
            state_d = ST_READ;
            idx_d   = '0;
          end
        end
        ST_READ: begin
          if (ram_rdata != '0) begin
            i_d     = idx_q;
            n_d     = ram_rdata;
            state_d = ST_PRESENT;
          end else if (idx_q == LAST_BIN) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + BIN_ONE;
          end
        end
        ST_PRESENT: begin
          if (bin_ack) begin
            if (idx_q == LAST_BIN) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_READ;
              idx_d   = idx_q + BIN_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      i       <= '0;
      n_i     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      i       <= i_d;
      n_i     <= n_d;
    end
  end

  assign bin_valid   = (state_q == ST_PRESENT);
  assign stream_done = (state_q == ST_DONE);
  assign busy        = (state_q == ST_CLEAR) || (state_q == ST_DRAIN) ||
                       (state_q == ST_READ)  || (state_q == ST_PRESENT);

endmodule

// File: tb/tb_histogram_bin_streamer.sv
// Scoreboard bench: a reference histogram predicts the (i, n_i) replay; a negedge monitor checks each handshake.
module tb_histogram_bin_streamer;

  localparam int NB = 256;

  logic        clk = 1'b0;
  logic        reset, clear, pix_valid, frame_end, bin_ack;
  logic [7:0]  pix, i;
  logic [31:0] n_i, total_pixels;
  logic        bin_valid, busy, stream_done;

  logic        reset4, clear4, pix_valid4, frame_end4, bin_ack4;
  logic [7:0]  pix4, i4;
  logic [3:0]  n_i4, total4;
  logic        bin_valid4, busy4, done4;

  typedef struct packed {
    logic [7:0]  bin;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned hist[NB];
  int unsigned model_total;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  histogram_bin_streamer dut (
    .clk(clk), .reset(reset), .clear(clear), .pix_valid(pix_valid), .pix(pix),
    .frame_end(frame_end), .i(i), .n_i(n_i), .bin_valid(bin_valid), .bin_ack(bin_ack),
    .busy(busy), .stream_done(stream_done), .total_pixels(total_pixels)
  );

  histogram_bin_streamer #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset4), .clear(clear4), .pix_valid(pix_valid4), .pix(pix4),
    .frame_end(frame_end4), .i(i4), .n_i(n_i4), .bin_valid(bin_valid4), .bin_ack(bin_ack4),
    .busy(busy4), .stream_done(done4), .total_pixels(total4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A handshake completes on the next rising edge whenever valid and ack are both high here.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bin_valid && bin_ack && !reset) begin
      if (exp_q.size() == 0) begin
        check("extra_bin", 32'(bin_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("bin_i", 32'(i), 32'(e.bin));
        check("bin_n", n_i, e.cnt);
      end
    end
  end

  task automatic start_frame();
    int n;
    exp_q.delete();
    for (int k = 0; k < NB; k++) hist[k] = 0;
    model_total = 0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_bin_valid", 32'(bin_valid), 0);
    check("clr_stream_done", 32'(stream_done), 0);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check("clear_cycles", n, NB);
  endtask

  task automatic send_pix(input logic [7:0] p);
    pix_valid = 1'b1;
    pix = p;
    hist[p]++;
    model_total++;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic end_frame(input bit with_pix, input logic [7:0] p);
    frame_end = 1'b1;
    if (with_pix) begin
      pix_valid = 1'b1;
      pix = p;
      hist[p]++;
      model_total++;
    end
    tick();
    frame_end = 1'b0;
    pix_valid = 1'b0;
    for (int k = 0; k < NB; k++)
      if (hist[k] != 0) exp_q.push_back('{bin: 8'(k), cnt: hist[k]});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!stream_done && n < 2000) begin
      tick();
      n++;
    end
    check("stream_done", 32'(stream_done), 1);
    check("queue_drained", exp_q.size(), 0);
    check("total_pixels", total_pixels, model_total);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bin_valid && n < 600) begin
      tick();
      n++;
    end
    check("bin_valid_seen", 32'(bin_valid), 1);
  endtask

  initial begin
    int n;
    bit stable;
    reset = 1'b1; clear = 1'b0; pix_valid = 1'b0; pix = '0; frame_end = 1'b0; bin_ack = 1'b1;
    reset4 = 1'b1; clear4 = 1'b0; pix_valid4 = 1'b0; pix4 = '0; frame_end4 = 1'b0; bin_ack4 = 1'b1;
    repeat (3) tick();
    check("rst_i", 32'(i), 0);
    check("rst_n_i", n_i, 0);
    check("rst_bin_valid", 32'(bin_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stream_done", 32'(stream_done), 0);
    check("rst_total", total_pixels, 0);
    reset = 1'b0;
    reset4 = 1'b0;
    tick();

    // IDLE ignores everything but clear
    frame_end = 1'b1; pix_valid = 1'b1; pix = 8'd3;
    tick();
    frame_end = 1'b0; pix_valid = 1'b0;
    check("idle_ignore_busy", 32'(busy), 0);

    // Empty frame: 2 drain cycles plus 256 skipped reads, no handshakes
    start_frame();
    end_frame(1'b0, '0);
    wait_done(n);
    check("empty_latency", n, 2 + NB);

    // Back-to-back and one-apart repeats of the same bin
    start_frame();
    repeat (5) send_pix(8'd7);
    send_pix(8'd7);
    send_pix(8'd3);
    send_pix(8'd7);
    end_frame(1'b0, '0);
    wait_done(n);

    // Downstream stall holds the presented bin
    start_frame();
    bin_ack = 1'b0;
    send_pix(8'd0);
    send_pix(8'd255);
    send_pix(8'd255);
    end_frame(1'b0, '0);
    wait_valid();
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!bin_valid || i !== 8'd0 || n_i !== 32'd1) stable = 1'b0;
    end
    check("stall_stable", 32'(stable), 1);
    bin_ack = 1'b1;
    tick();
    check("ack_drop", 32'(bin_valid), 0);
    wait_done(n);

    // Pixel with frame_end counts; pixel after it does not
    start_frame();
    end_frame(1'b1, 8'd9);
    pix_valid = 1'b1; pix = 8'd9;
    tick();
    pix_valid = 1'b0;
    wait_done(n);

    // Abort mid-presentation, then a fresh frame must not carry old counts
    start_frame();
    bin_ack = 1'b0;
    send_pix(8'd4);
    send_pix(8'd4);
    send_pix(8'd6);
    end_frame(1'b0, '0);
    wait_valid();
    check("abort_i", 32'(i), 4);
    start_frame();
    bin_ack = 1'b1;
    send_pix(8'd5);
    end_frame(1'b0, '0);
    wait_done(n);

    // Synchronous reset in the middle of accumulation
    start_frame();
    send_pix(8'd1);
    send_pix(8'd2);
    pix_valid = 1'b1; pix = 8'd2; reset = 1'b1;
    tick();
    reset = 1'b0; pix_valid = 1'b0;
    check("midrst_i", 32'(i), 0);
    check("midrst_n_i", n_i, 0);
    check("midrst_bin_valid", 32'(bin_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(stream_done), 0);
    check("midrst_total", total_pixels, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    tick();
    check("midrst_idle", 32'(busy), 0);

    // Saturation on the 4-bit count instance
    clear4 = 1'b1;
    tick();
    clear4 = 1'b0;
    repeat (NB) tick();
    pix_valid4 = 1'b1; pix4 = 8'd1;
    repeat (20) tick();
    pix_valid4 = 1'b0;
    frame_end4 = 1'b1;
    tick();
    frame_end4 = 1'b0;
    check("sat_total", 32'(total4), 15);
    n = 0;
    while (!bin_valid4 && n < 600) begin
      tick();
      n++;
    end
    check("sat_bin_valid", 32'(bin_valid4), 1);
    check("sat_i", 32'(i4), 1);
    check("sat_n_i", 32'(n_i4), 15);
    n = 0;
    while (!done4 && n < 600) begin
      tick();
      n++;
    end
    check("sat_done", 32'(done4), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/histogram_bin_streamer.md
# histogram_bin_streamer

Builds a per-frame grey-level histogram from an 8-bit pixel stream, then replays it bin by bin as (i, n_i) pairs to the class-probability/mean accumulators of the Otsu threshold datapath. It is the producer end of the (i, n_i) bin interface:
- it presents one non-empty bin at a time;
- it waits for the downstream accumulator to acknowledge completion before advancing.

## Interface
Parameters:
- NUM_BINS, 256, number of histogram bins (power of two)
- BIN_WIDTH, 8, width of bin index / pixel value (log2 NUM_BINS)
- COUNT_WIDTH, 32, width of each bin count and of total_pixels

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- clear  in  1  pulse: start a new frame (zero histogram, abort any stream)
- pix_valid  in  1  pixel present this cycle
- pix  in  BIN_WIDTH  pixel grey level
- frame_end  in  1  pulse: last pixel of frame done; begin streaming
- i  out  BIN_WIDTH  current bin index
- n_i  out  COUNT_WIDTH  count of bin i
- bin_valid  out  1  i/n_i valid, held until acknowledged
- bin_ack  in  1  downstream finished bin i
- busy  out  1  high in CLEAR, DRAIN, READ, PRESENT
- stream_done  out  1  level: full histogram replayed; cleared by clear/reset
- total_pixels  out  COUNT_WIDTH  pixels counted this frame (saturating)

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, READ, PRESENT, DONE.
- IDLE: after reset. clear -> CLEAR. All other inputs are ignored.
- CLEAR: writes 0 to bins 0..NUM_BINS-1, one per cycle, and zeroes total_pixels. Exits to ACCUM after the last bin.
- ACCUM: each pix_valid increments bin[pix] by read-modify-write.
  - Read latency is 1 cycle; the write lands 2 cycles after pix_valid.
  - Forwarding covers back-to-back and one-apart same-bin pixels, so 1 pixel/cycle is sustained with exact counts.
  - Counts saturate at 2^COUNT_WIDTH-1. total_pixels increments per pixel and saturates.
- frame_end in ACCUM -> DRAIN. A pixel in the same cycle is counted. pix_valid after frame_end is ignored.
- DRAIN: 2 cycles, until outstanding writes retire, then READ with index 0.
- READ: issues a read of bin[index].
  - Count 0: skip (no handshake); increment index and stay in READ.
  - Count nonzero: load i/n_i and go to PRESENT.
- PRESENT: bin_valid=1, with i and n_i stable.
  - bin_ack=1 sampled -> bin_valid=0 the next cycle.
  - If index==NUM_BINS-1 -> DONE; else index+1 -> READ.
  - bin_ack outside PRESENT is ignored.
- Skipped zero bins that reach index NUM_BINS-1 also go to DONE.
- DONE: stream_done=1, held until clear (-> CLEAR) or reset.
- clear in any state except IDLE/DONE: abort.
  - bin_valid drops next cycle; go to CLEAR; stream_done=0.
- clear during CLEAR restarts the clear from bin 0.

## Timing
- Reset values: i=0, n_i=0, bin_valid=0, busy=0, stream_done=0, total_pixels=0, state IDLE.
- Histogram contents are not reset; CLEAR initialises them.
- CLEAR: exactly NUM_BINS cycles. pix_valid during CLEAR is dropped.
- ACCUM: throughput 1 pixel/cycle. total_pixels is updated 1 cycle after pix_valid.
- frame_end -> first READ: 3 cycles (1 transition + 2 DRAIN).
- READ -> bin_valid: 1 cycle (registered). Each zero bin costs 1 cycle.
- Minimum per non-empty bin: 2 cycles (READ + PRESENT with immediate ack).
- bin_ack may arrive any number of cycles later; bin_valid never drops without ack except on clear/reset.
- Synchronous reset mid-operation: returns to IDLE next edge, outputs at reset values. A frame in progress is lost.

## Structure
- Shared package histogram_pkg:
  - state enum;
  - NUM_BINS, BIN_WIDTH, COUNT_WIDTH defaults;
  - COUNT_MAX constant.
- Sub-module hist_ram: NUM_BINS x COUNT_WIDTH simple dual-port RAM.
  - One write port, one read port, 1-cycle registered read.
  - No reset.
- Forwarding/saturation logic and the FSM live in the top module.

## Test plan
- Reset/clear: reset then clear; check CLEAR lasts 256 cycles with busy=1.
  - frame_end with no pixels -> no bin_valid ever.
  - stream_done=1 after 256 READ cycles; total_pixels=0.
- Back-to-back same bin: 5 consecutive pix=7, then pix=7,3,7.
  - Expect exactly two handshakes: (i=3,n_i=1), then (i=7,n_i=7), in index order. total_pixels=8.
- Handshake stall: pixels 0,255,255.
  - Hold bin_ack=0 for 10 cycles; bin_valid and (i=0,n_i=1) stay stable.
  - Ack -> next is (i=255,n_i=2), then stream_done.
- frame_end coincident with pix_valid (pix=9): bin 9 is reported as n_i=1.
  - pix_valid=1 (pix=9) after frame_end is not counted.
- Abort: clear while PRESENT on i=4 -> bin_valid=0 next cycle, CLEAR restarts.
  - The new frame's histogram contains no prior counts.
- Saturation (COUNT_WIDTH=4): 20 pixels of value 1 -> n_i=15, total_pixels=15.
  - Synchronous reset mid-ACCUM -> IDLE with all outputs at reset values.
